// File: rtl/spi_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// spi_frame_decoder_if
// Bundles the SPI byte-core side and the register-access side of the frame
// decoder into one interface.
//   master : decoder view (drives spi_din and the register bus, samples
//            spi_dout / spi_data_valid / reg_rdata)
//   slave  : environment view (SPI byte core plus register file)
// Signals:
//   spi_dout        received byte from the SPI core
//   spi_data_valid  byte-done flag from the SPI core (asynchronous to clk)
//   spi_din         byte handed back to the SPI core for MISO
//   reg_addr        register address
//   reg_wdata       register write data {HI,LO}
//   reg_wr_en       one-cycle write strobe
//   reg_rd_en       one-cycle read strobe
//   reg_rdata       read data, valid one clk after reg_rd_en
//   frame_err       one-cycle pulse when a frame is aborted by timeout
// ---------------------------------------------------------------------------
interface spi_frame_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
);
    logic [DATA_WIDTH-1:0]   spi_dout;
    logic                    spi_data_valid;
    logic [DATA_WIDTH-1:0]   spi_din;
    logic [ADDR_WIDTH-1:0]   reg_addr;
    logic [2*DATA_WIDTH-1:0] reg_wdata;
    logic                    reg_wr_en;
    logic                    reg_rd_en;
    logic [2*DATA_WIDTH-1:0] reg_rdata;
    logic                    frame_err;

    modport master (
        input  spi_dout, spi_data_valid, reg_rdata,
        output spi_din, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err
    );

    modport slave (
        output spi_dout, spi_data_valid, reg_rdata,
        input  spi_din, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err
    );
endinterface

// File: rtl/spi_frame_decoder.sv
// ---------------------------------------------------------------------------
// spi_frame_decoder
// Resynchronises the SPI byte core's data_valid into clk, assembles bytes into
// register-access frames and issues one-cycle register write/read strobes.
//   WRITE frame: CMD,HI,LO        READ frame: CMD,PAD,X,X (MISO: HI, LO, 0)
//   CMD[DATA_WIDTH-1] = 1 for write, CMD[ADDR_WIDTH-1:0] = register address.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  spi_frame_decoder_if.master (SPI core + register bus signals)
// ---------------------------------------------------------------------------
module spi_frame_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 7,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    spi_frame_decoder_if.master bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_CAP = 3'd1,
        S_WR_HI  = 3'd2,
        S_WR_LO  = 3'd3,
        S_RD_B1  = 3'd4,
        S_RD_B2  = 3'd5,
        S_RD_B3  = 3'd6
    } state_t;

    state_t                  state_r, state_s;
    logic                    sync1_r, sync2_r, sync3_r;
    logic                    byte_stb_r;
    logic [DATA_WIDTH-1:0]   byte_q_r;
    logic [CW-1:0]           cnt_r;
    logic                    timeout_s;

    logic [DATA_WIDTH-1:0]   hi_r, hi_s;
    logic [DATA_WIDTH-1:0]   rd_buf_lo_r, rd_buf_lo_s;
    logic [DATA_WIDTH-1:0]   din_r, din_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [2*DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic                    wr_en_r, wr_en_s;
    logic                    rd_en_r, rd_en_s;
    logic                    err_r, err_s;

    // Terminal count; a byte strobe on the same cycle takes priority.
    assign timeout_s = (state_r != S_IDLE) && !byte_stb_r &&
                       (cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // Two-flop synchroniser, edge-detect flop, registered byte strobe and byte capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            sync3_r    <= 1'b0;
            byte_stb_r <= 1'b0;
            byte_q_r   <= '0;
        end else begin
            sync1_r    <= bus.spi_data_valid;
            sync2_r    <= sync1_r;
            sync3_r    <= sync2_r;
            byte_stb_r <= sync2_r & ~sync3_r;
            // spi_dout is held by the core long after data_valid, so it is
            // stable by the time the synchronised edge arrives.
            if (sync2_r & ~sync3_r) begin
                byte_q_r <= bus.spi_dout;
            end else begin
                byte_q_r <= byte_q_r;
            end
        end
    end

    // In-frame idle counter: restarts on every byte, parked while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if ((state_r == S_IDLE) || byte_stb_r || timeout_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        if (timeout_s) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (byte_stb_r) begin
                        state_s = byte_q_r[DATA_WIDTH-1] ? S_WR_HI : S_RD_CAP;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                // First RD_CAP cycle carries reg_rd_en; data is sampled on the second.
                S_RD_CAP: state_s = rd_en_r ? S_RD_CAP : S_RD_B1;
                S_WR_HI:  state_s = byte_stb_r ? S_WR_LO : S_WR_HI;
                S_WR_LO:  state_s = byte_stb_r ? S_IDLE  : S_WR_LO;
                S_RD_B1:  state_s = byte_stb_r ? S_RD_B2 : S_RD_B1;
                S_RD_B2:  state_s = byte_stb_r ? S_RD_B3 : S_RD_B2;
                S_RD_B3:  state_s = byte_stb_r ? S_IDLE  : S_RD_B3;
                default:  state_s = S_IDLE;
            endcase
        end
    end

    // FSM output logic: next values of the registered outputs and frame buffers.
    always_comb begin
        hi_s        = hi_r;
        rd_buf_lo_s = rd_buf_lo_r;
        din_s       = din_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        err_s       = 1'b0;
        if (timeout_s) begin
            err_s = 1'b1;
            din_s = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (byte_stb_r) begin
                        addr_s  = byte_q_r[ADDR_WIDTH-1:0];
                        rd_en_s = ~byte_q_r[DATA_WIDTH-1];
                    end else begin
                        addr_s  = addr_r;
                    end
                end
                S_RD_CAP: begin
                    // Any strobe landing here is dropped.
                    if (!rd_en_r) begin
                        rd_buf_lo_s = bus.reg_rdata[DATA_WIDTH-1:0];
                        din_s       = bus.reg_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        din_s       = din_r;
                    end
                end
                S_WR_HI: begin
                    if (byte_stb_r) begin
                        hi_s = byte_q_r;
                    end else begin
                        hi_s = hi_r;
                    end
                end
                S_WR_LO: begin
                    if (byte_stb_r) begin
                        wdata_s = {hi_r, byte_q_r};
                        wr_en_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                S_RD_B1: begin
                    if (byte_stb_r) begin
                        din_s = rd_buf_lo_r;
                    end else begin
                        din_s = din_r;
                    end
                end
                S_RD_B2: begin
                    if (byte_stb_r) begin
                        din_s = '0;
                    end else begin
                        din_s = din_r;
                    end
                end
                default: begin
                    din_s = din_r;
                end
            endcase
        end
    end

    // Output and frame-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r        <= '0;
            rd_buf_lo_r <= '0;
            din_r       <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            wr_en_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            hi_r        <= hi_s;
            rd_buf_lo_r <= rd_buf_lo_s;
            din_r       <= din_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            wr_en_r     <= wr_en_s;
            rd_en_r     <= rd_en_s;
            err_r       <= err_s;
        end
    end

    assign bus.spi_din   = din_r;
    assign bus.reg_addr  = addr_r;
    assign bus.reg_wdata = wdata_r;
    assign bus.reg_wr_en = wr_en_r;
    assign bus.reg_rd_en = rd_en_r;
    assign bus.frame_err = err_r;
endmodule
